// File: rtl/mem_arbiter_ctrl_if.sv
// Bundle between the two requesters, the arbiter/controller and the single-port RAM.
//   slave  : the controller's view (takes requests and RAM read data, drives grants, valids and
//            the RAM address/we/data lines).
//   master : the environment's view (requesters plus RAM).
// Signals:
//   rqN_req/we/addr/wdata  request side, held stable until rqN_gnt
//   rqN_gnt, rqN_rvalid    one-cycle pulses back to requester N
//   mc_rdata               shared registered read data
//   mc_address_mem, mem_we, mem_data_in   RAM control/write lines
//   mem_data_out           RAM read data (registered-address RAM)
interface mem_arbiter_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
);
    logic              rq0_req;
    logic              rq0_we;
    logic [ADDR_W-1:0] rq0_addr;
    logic [DATA_W-1:0] rq0_wdata;
    logic              rq0_gnt;
    logic              rq0_rvalid;
    logic              rq1_req;
    logic              rq1_we;
    logic [ADDR_W-1:0] rq1_addr;
    logic [DATA_W-1:0] rq1_wdata;
    logic              rq1_gnt;
    logic              rq1_rvalid;
    logic [DATA_W-1:0] mc_rdata;
    logic [ADDR_W-1:0] mc_address_mem;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
        input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
        input  mem_data_out,
        output rq0_gnt, rq0_rvalid, rq1_gnt, rq1_rvalid,
        output mc_rdata, mc_address_mem, mem_we, mem_data_in
    );

    modport master (
        output rq0_req, rq0_we, rq0_addr, rq0_wdata,
        output rq1_req, rq1_we, rq1_addr, rq1_wdata,
        output mem_data_out,
        input  rq0_gnt, rq0_rvalid, rq1_gnt, rq1_rvalid,
        input  mc_rdata, mc_address_mem, mem_we, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// Two-requester arbiter and controller for a single-port RAM with registered read address.
// One transaction in flight: IDLE (arbitrate + latch) -> ISSUE (grant, drive RAM) -> IDLE for a
// write, or -> RDWAIT (capture RAM data) -> IDLE with an rvalid pulse for a read.
// Ports:
//   mem_clk  rising-edge clock
//   mem_rst  asynchronous active-high reset
//   bus_io   mem_arbiter_ctrl_if.slave (requests, grants, read data, RAM lines)
// Build option: define MC_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0
// wins every tie and no pointer flop exists.
// DATA_W/ADDR_W must match the interface instance parameters.
module mem_arbiter_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              mem_clk,
    input  logic              mem_rst,
    mem_arbiter_ctrl_if.slave bus_io
);

    typedef enum logic [1:0] {StIdle, StIssue, StRdWait} state_e;

    state_e            state_q, state_d;
    logic              sel_q, sel_d;       // requester owning the in-flight transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid0_q, rvalid0_d;
    logic              rvalid1_q, rvalid1_d;
    logic              any_req;
    logic              win;                // requester chosen this cycle (meaningful if any_req)

    assign any_req = bus_io.rq0_req | bus_io.rq1_req;

`ifdef MC_ROUND_ROBIN_EN
    logic rr_q, rr_d;                      // requester that wins the next tie

    always_comb begin
        win  = (bus_io.rq0_req && bus_io.rq1_req) ? rr_q : !bus_io.rq0_req;
        rr_d = rr_q;
        // Every grant hands the next tie to the other requester.
        if (state_q == StIdle && any_req) begin
            rr_d = !win;
        end
    end

    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Fixed priority: requester 0 whenever it asks.
    always_comb begin
        win = !bus_io.rq0_req;
    end
`endif

    // State register
    always_ff @(posedge mem_clk or posedge mem_rst) begin
        if (mem_rst) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    sel_d   = win;
                    we_d    = win ? bus_io.rq1_we : bus_io.rq0_we;
                    addr_d  = win ? bus_io.rq1_addr : bus_io.rq0_addr;
                    // Write data only moves on writes so mem_data_in keeps the last written word.
                    if (we_d) begin
                        wdata_d = win ? bus_io.rq1_wdata : bus_io.rq0_wdata;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = we_q ? StIdle : StRdWait;
            end
            StRdWait: begin
                // RAM registered the address at the end of ISSUE; its data is valid now.
                rdata_d   = bus_io.mem_data_out;
                rvalid0_d = !sel_q;
                rvalid1_d = sel_q;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        bus_io.rq0_gnt        = (state_q == StIssue) && !sel_q;
        bus_io.rq1_gnt        = (state_q == StIssue) && sel_q;
        bus_io.mem_we         = (state_q == StIssue) && we_q;
        bus_io.mc_address_mem = addr_q;
        bus_io.mem_data_in    = wdata_q;
        bus_io.mc_rdata       = rdata_q;
        bus_io.rq0_rvalid     = rvalid0_q;
        bus_io.rq1_rvalid     = rvalid1_q;
    end

endmodule
